// File: rtl/mod_reduce.sv
// Restoring shift-subtract reducer: r = x mod q (or 2x mod q), one dividend bit per clock.
// Optional doubling is built only when MOD_REDUCE_DBL_EN is defined.
module mod_reduce #(
    parameter int BITWIDTH = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*BITWIDTH-1:0] x,
    input  logic [BITWIDTH-1:0]   q,
    input  logic                  dbl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITWIDTH-1:0]   r,
    output logic                  err
);

    localparam int DW = 2 * BITWIDTH;
`ifdef MOD_REDUCE_DBL_EN
    localparam int NMAX = DW + 1;
`else
    localparam int NMAX = DW;
`endif
    localparam int CW = $clog2(NMAX + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_reg, state_next;
    logic [DW-1:0]       d_reg, d_next;
    logic [BITWIDTH-1:0] q_reg, q_next;
    logic                qz_reg, qz_next;
    logic [BITWIDTH:0]   rem_reg, rem_next;
    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [BITWIDTH-1:0] r_reg, r_next;
    logic                err_reg, err_next;

    logic [BITWIDTH:0]   t;
    logic [BITWIDTH:0]   t_sub;
    logic [BITWIDTH:0]   rem_step;
    logic [CW-1:0]       n_load;
    logic                unused_rem_msb;

    // Doubling appends a zero LSB, so both builds shift the same register
    // MSB first; only the bit count differs.
`ifdef MOD_REDUCE_DBL_EN
    assign n_load = dbl ? CW'(DW + 1) : CW'(DW);
`else
    logic unused_dbl;
    assign unused_dbl = dbl;
    assign n_load     = CW'(DW);
`endif

    assign in_ready       = (state_reg == IDLE) && !sys_rst;
    assign out_valid      = (state_reg == DONE);
    assign r              = r_reg;
    assign err            = err_reg;
    assign unused_rem_msb = rem_reg[BITWIDTH];

    assign t        = {rem_reg[BITWIDTH-1:0], d_reg[DW-1]};
    assign t_sub    = t - {1'b0, q_reg};
    assign rem_step = (t >= {1'b0, q_reg}) ? t_sub : t;

    always_comb begin
        state_next = state_reg;
        d_next     = d_reg;
        q_next     = q_reg;
        qz_next    = qz_reg;
        rem_next   = rem_reg;
        cnt_next   = cnt_reg;
        r_next     = r_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready) begin
                    d_next     = x;
                    q_next     = q;
                    qz_next    = (q == '0);
                    rem_next   = '0;
                    // A zero modulus takes one RUN cycle so the error result
                    // appears one edge after accept.
                    cnt_next   = (q == '0) ? CW'(1) : n_load;
                    state_next = RUN;
                end
            end
            RUN: begin
                rem_next = rem_step;
                d_next   = {d_reg[DW-2:0], 1'b0};
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    r_next     = qz_reg ? '0 : rem_step[BITWIDTH-1:0];
                    err_next   = qz_reg;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg <= IDLE;
            d_reg     <= '0;
            q_reg     <= '0;
            qz_reg    <= 1'b0;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            r_reg     <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            d_reg     <= d_next;
            q_reg     <= q_next;
            qz_reg    <= qz_next;
            rem_reg   <= rem_next;
            cnt_reg   <= cnt_next;
            r_reg     <= r_next;
            err_reg   <= err_next;
        end
    end

endmodule
